// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: IDLE -> REQ -> DONE handshake with a variable-latency data memory.
// Optional MISALIGN_CHECK_EN: misaligned accesses skip memory, return zero and flag misalignM.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        memWriteM,
    input  logic [1:0]  resultSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] writeDataM,
    output logic [31:0] readDataM,
    output logic        stallM,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic        memAck,
    input  logic [31:0] memRData
`ifdef MISALIGN_CHECK_EN
    ,
    output logic        misalignM
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t state;
    logic   access;
    logic   is_load;

    // Store wins when both store and load-select are set.
    assign access  = memWriteM | (resultSrcM == 2'b01);
    assign is_load = ~memWriteM & (resultSrcM == 2'b01);

`ifdef MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |ALUResultM[1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            readDataM <= 32'b0;
`ifdef MISALIGN_CHECK_EN
            misalignM <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_CHECK_EN
            misalignM <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (access) begin
`ifdef MISALIGN_CHECK_EN
                        if (misaligned) begin
                            state     <= DONE;
                            misalignM <= 1'b1;
                            if (is_load)
                                readDataM <= 32'b0;
                        end else begin
                            state <= REQ;
                        end
`else
                        state <= REQ;
`endif
                    end
                end
                REQ: begin
                    if (memAck) begin
                        state <= DONE;
                        if (is_load)
                            readDataM <= memRData;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // memReq decodes straight from state so an async reset drops it immediately.
    assign memReq   = (state == REQ);
    assign stallM   = ((state == IDLE) & access) | (state == REQ);
    assign memWe    = memWriteM;
    assign memAddr  = ALUResultM & ~32'h3;
    assign memWData = writeDataM;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: random instruction stream against a transaction-level model
// plus directed store/load/reset scenarios; memory responder with random latency and stray acks.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        memWriteM;
    logic [1:0]  resultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] writeDataM;
    logic [31:0] readDataM;
    logic        stallM;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic        memAck;
    logic [31:0] memRData;
`ifdef MISALIGN_CHECK_EN
    logic        misalignM;
`endif

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .memWriteM(memWriteM), .resultSrcM(resultSrcM),
        .ALUResultM(ALUResultM), .writeDataM(writeDataM),
        .readDataM(readDataM), .stallM(stallM),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memAck(memAck), .memRData(memRData)
`ifdef MISALIGN_CHECK_EN
        , .misalignM(misalignM)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        ld;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: random (or fixed) latency, random data, stray acks outside bursts.
    logic        resp_en = 1'b1;
    logic        resp_ack = 1'b0;
    logic [31:0] resp_data = 32'h0;
    logic        manual_ack = 1'b0;
    logic [31:0] manual_data = 32'h0;
    int          fixed_lat = -1;
    logic        fixed_data_en = 1'b0;
    logic [31:0] fixed_data = 32'h0;
    int          cnt = 0;
    int          lat = 0;

    assign memAck   = resp_en ? resp_ack  : manual_ack;
    assign memRData = resp_en ? resp_data : manual_data;

    always @(posedge clk) begin
        #1;
        if (!memReq) begin
            cnt       = 0;
            resp_ack  = ($urandom % 4) == 0;
            resp_data = $urandom;
        end else begin
            if (cnt == 0) lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom % 4);
            resp_ack  = (cnt == lat);
            resp_data = fixed_data_en ? fixed_data : $urandom;
            cnt++;
        end
    end

    // Monitor: pops the expected transaction on each handshake, tracks load data and stall lengths.
    logic [31:0] exp_rd = 32'h0;
    int          run = 0;
    int          reqcnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            exp_rd = 32'h0;
            run    = 0;
            reqcnt = 0;
        end else begin
`ifdef MISALIGN_CHECK_EN
            if (misalignM) begin
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL misalign_unexpected: got misalignM=1 expected no access pending");
                end else begin
                    e = exp_q.pop_front();
                    chk("misalign_flag", {31'b0, e.mis}, 32'd1);
                    if (e.ld) exp_rd = 32'h0;
                end
            end
`endif
            chk("read_data", readDataM, exp_rd);
            if (memReq) begin
                reqcnt++;
                if (memAck) begin
                    if (exp_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL req_unexpected: got memReq handshake expected none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_mis", {31'b0, e.mis}, 32'd0);
                        chk("mem_we", {31'b0, memWe}, {31'b0, e.we});
                        chk("mem_addr", memAddr, e.addr);
                        if (e.we) chk("mem_wdata", memWData, e.wdata);
                        if (e.ld) exp_rd = memRData;
                    end
                end
            end
            if (stallM) run++;
            else if (run > 0) begin
                chk("stall_len", run, reqcnt + 1);
                run    = 0;
                reqcnt = 0;
            end
        end
    end

    // Present one instruction in M and hold it until the stage stops stalling.
    task automatic issue(input logic we, input logic [1:0] rs, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        memWriteM  = we;
        resultSrcM = rs;
        ALUResultM = a;
        writeDataM = d;
        if (we || rs == 2'b01) begin
            e.we    = we;
            e.ld    = !we;
            e.addr  = {a[31:2], 2'b00};
            e.wdata = d;
            e.mis   = 1'b0;
`ifdef MISALIGN_CHECK_EN
            e.mis   = |a[1:0];
`endif
            exp_q.push_back(e);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stallM && n < 64);
        chk("stall_timeout", {31'b0, stallM}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; memWriteM = 1'b0; resultSrcM = 2'b00; ALUResultM = 32'h0; writeDataM = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_read_data", readDataM, 32'h0);
        chk("rst_mem_req", {31'b0, memReq}, 32'd0);
        chk("rst_stall", {31'b0, stallM}, 32'd0);
        #1 rst = 1'b0;

        // Store with immediate ack, then 4-cycle load with fixed data.
        fixed_lat = 0;
        issue(1'b1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF);
        fixed_lat = 3; fixed_data_en = 1'b1; fixed_data = 32'h1234_5678;
        issue(1'b0, 2'b01, 32'h0000_0020, 32'h0);
        chk("load_data_done", readDataM, 32'h1234_5678);
        fixed_lat = -1; fixed_data_en = 1'b0;

        // Load followed directly by store, and store+load-select together.
        issue(1'b0, 2'b01, 32'h0000_0104, 32'h0);
        issue(1'b1, 2'b00, 32'h0000_0108, 32'hA5A5_5A5A);
        issue(1'b1, 2'b01, 32'h0000_010C, 32'h0BAD_F00D);

        // Low address bits: dropped, or trapped when the check is built in.
        issue(1'b0, 2'b01, 32'h0000_0013, 32'h0);

        // Stray acks while idle with no access.
        resp_en = 1'b0; manual_ack = 1'b1; manual_data = 32'hFFFF_FFFF;
        repeat (3) issue(1'b0, 2'b10, $urandom, $urandom);
        manual_ack = 1'b0; resp_en = 1'b1;

        for (int i = 0; i < 250; i++) begin
            int k;
            k = $urandom % 10;
            if (k < 4)      issue(1'b1, 2'($urandom), $urandom, $urandom);
            else if (k < 8) issue(1'b0, 2'b01, $urandom, $urandom);
            else            issue(1'b0, (($urandom % 2) == 0) ? 2'b00 : 2'b10, $urandom, $urandom);
        end

        // Make sure readDataM is nonzero before the reset test.
        fixed_data_en = 1'b1; fixed_data = 32'h5555_AAAA;
        issue(1'b0, 2'b01, 32'h0000_0200, 32'h0);
        fixed_data_en = 1'b0;

        // Reset in the second REQ cycle of a load; a late ack must not be captured.
        fixed_lat = 10;
        @(posedge clk); #1;
        memWriteM = 1'b0; resultSrcM = 2'b01; ALUResultM = 32'h0000_0040;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_req", {31'b0, memReq}, 32'd0);
        chk("rst_mid_rd", readDataM, 32'h0);
        resultSrcM = 2'b00;
        resp_en = 1'b0; manual_ack = 1'b1; manual_data = 32'hCAFE_F00D;
        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("late_ack_rd", readDataM, 32'h0);
        chk("late_ack_req", {31'b0, memReq}, 32'd0);
        #1 manual_ack = 1'b0; resp_en = 1'b1; fixed_lat = -1;

        for (int i = 0; i < 40; i++)
            issue(($urandom % 2) == 1, 2'b01, $urandom, $urandom);

        repeat (3) issue(1'b0, 2'b00, 32'h0, 32'h0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
